// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// iteration-counter sizing and the controller state encoding.
package div_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    // Counter must reach the step count itself, so it needs one extra code.
    function automatic int cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIVIDEND_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step_4b.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor and subtract when it fits.
module div_step_4b #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   r_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] r_out,
    output logic                 q_bit
);

    // The result is always below the divisor, so the low bits of the
    // difference are exact even though the subtraction wraps.
    always_comb begin
        q_bit = (r_in >= {1'b0, divisor});
        r_out = q_bit ? (r_in[DIVISOR_W-1:0] - divisor) : r_in[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/seq_divider_8b4b.sv
// Sequential unsigned divider, one quotient bit per clock, MSB first.
// Results are held in output registers that only change on the done edge.
module seq_divider_8b4b
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk_div,
    input  logic                  reset_div,
    input  logic                  start_div,
    input  logic [DIVIDEND_W-1:0] dividend_div,
    input  logic [DIVISOR_W-1:0]  divisor_div,
    output logic                  busy_div,
    output logic                  done_div,
    output logic [DIVIDEND_W-1:0] quotient_div,
    output logic [DIVISOR_W-1:0]  remainder_div,
    output logic                  div_by_zero_div
);

    localparam int CW = (DIVIDEND_W == DIVIDEND_W_DEF) ? CNT_W : cnt_width(DIVIDEND_W);

    div_state_t state, state_nxt;

    logic [DIVIDEND_W-1:0] dividend_reg;
    logic [DIVIDEND_W-1:0] quot_shift;
    logic [DIVISOR_W-1:0]  divisor_reg;
    logic [DIVISOR_W-1:0]  rem_reg;
    logic [CW-1:0]         step_cnt;

    logic [DIVISOR_W:0]    step_r_in;
    logic [DIVISOR_W-1:0]  step_r_out;
    logic                  step_q_bit;

    logic start_ok;
    logic div_zero;
    logic steps_done;

    assign start_ok   = start_div && (state != RUN);
    assign div_zero   = (divisor_reg == '0);
    assign steps_done = (step_cnt == CW'(DIVIDEND_W));
    assign step_r_in  = {rem_reg, dividend_reg[DIVIDEND_W-1]};

    assign busy_div = (state == RUN);
    assign done_div = (state == DONE);

    div_step_4b #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .r_in    (step_r_in),
        .divisor (divisor_reg),
        .r_out   (step_r_out),
        .q_bit   (step_q_bit)
    );

    always_ff @(posedge clk_div or posedge reset_div) begin
        if (reset_div) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN spends DIVIDEND_W cycles stepping plus one cycle publishing the
    // result; a zero divisor publishes immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_div) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (div_zero || steps_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = start_div ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_div or posedge reset_div) begin
        if (reset_div) begin
            dividend_reg    <= '0;
            divisor_reg     <= '0;
            rem_reg         <= '0;
            quot_shift      <= '0;
            step_cnt        <= '0;
            quotient_div    <= '0;
            remainder_div   <= '0;
            div_by_zero_div <= 1'b0;
        end else if (start_ok) begin
            dividend_reg <= dividend_div;
            divisor_reg  <= divisor_div;
            rem_reg      <= '0;
            quot_shift   <= '0;
            step_cnt     <= '0;
        end else if (state == RUN) begin
            if (div_zero) begin
                quotient_div    <= '1;
                remainder_div   <= '0;
                div_by_zero_div <= 1'b1;
            end else if (steps_done) begin
                quotient_div    <= quot_shift;
                remainder_div   <= rem_reg;
                div_by_zero_div <= 1'b0;
            end else begin
                rem_reg      <= step_r_out;
                quot_shift   <= {quot_shift[DIVIDEND_W-2:0], step_q_bit};
                dividend_reg <= {dividend_reg[DIVIDEND_W-2:0], 1'b0};
                step_cnt     <= step_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_8b4b.sv
// Directed bench for seq_divider_8b4b: expected results are queued when a
// start is driven and compared against the DUT when done pulses.
module tb_seq_divider_8b4b;

    logic       clk_div;
    logic       reset_div;
    logic       start_div;
    logic [7:0] dividend_div;
    logic [3:0] divisor_div;
    logic       busy_div;
    logic       done_div;
    logic [7:0] quotient_div;
    logic [3:0] remainder_div;
    logic       div_by_zero_div;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc;

    logic [7:0] prev_q;
    logic [3:0] prev_r;
    logic       prev_dbz;

    seq_divider_8b4b dut (
        .clk_div         (clk_div),
        .reset_div       (reset_div),
        .start_div       (start_div),
        .dividend_div    (dividend_div),
        .divisor_div     (divisor_div),
        .busy_div        (busy_div),
        .done_div        (done_div),
        .quotient_div    (quotient_div),
        .remainder_div   (remainder_div),
        .div_by_zero_div (div_by_zero_div)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    always @(posedge clk_div) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Queue the expected result, then pulse start for exactly one edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = 8'hFF; e.r = 4'd0; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 9;
        end
        sb.push_back(e);
        start_div    = 1'b1;
        dividend_div = a;
        divisor_div  = b;
        @(posedge clk_div);
        #1;
        start_div = 1'b0;
        start_cyc = cyc;
        chk("busy_after_start", busy_div, 1);
        chk("done_low_after_start", done_div, 0);
    endtask

    // Wait for done (bounded), verifying held outputs, latency and result.
    task automatic checkOutput();
        exp_t e;
        int   lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_div);
            #1;
            if (done_div === 1'b1) begin
                lat = cyc - start_cyc;
                break;
            end
            chk("hold_outputs", {quotient_div, remainder_div, div_by_zero_div},
                {prev_q, prev_r, prev_dbz});
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("quotient", quotient_div, e.q);
        chk("remainder", remainder_div, e.r);
        chk("div_by_zero", div_by_zero_div, e.dbz);
        chk("busy_at_done", busy_div, 0);
        prev_q   = e.q;
        prev_r   = e.r;
        prev_dbz = e.dbz;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_cnt;
        logic [7:0] ra;
        logic [3:0] rb;

        reset_div    = 1'b0;
        start_div    = 1'b0;
        dividend_div = '0;
        divisor_div  = '0;
        prev_q       = '0;
        prev_r       = '0;
        prev_dbz     = 1'b0;
        #1 reset_div = 1'b1;
        #20;
        chk("rst_busy", busy_div, 0);
        chk("rst_done", done_div, 0);
        chk("rst_quotient", quotient_div, 0);
        chk("rst_remainder", remainder_div, 0);
        chk("rst_dbz", div_by_zero_div, 0);
        #2 reset_div = 1'b0;
        @(posedge clk_div);
        #1;

        $display("[TB] basic and edge divisions");
        applyStimulus(8'd200, 4'd7);  checkOutput();
        applyStimulus(8'd255, 4'd1);  checkOutput();
        applyStimulus(8'd5,   4'd15); checkOutput();
        applyStimulus(8'd0,   4'd9);  checkOutput();
        applyStimulus(8'd255, 4'd15); checkOutput();

        $display("[TB] divide by zero");
        applyStimulus(8'd100, 4'd0);  checkOutput();
        applyStimulus(8'd77,  4'd3);  checkOutput();

        $display("[TB] start ignored while running, then back-to-back start");
        applyStimulus(8'd50, 4'd3);
        repeat (2) begin
            @(posedge clk_div);
            #1;
        end
        start_div    = 1'b1;
        dividend_div = 8'd9;
        divisor_div  = 4'd2;
        @(posedge clk_div);
        #1;
        start_div = 1'b0;
        checkOutput();
        applyStimulus(8'd9, 4'd2);
        checkOutput();

        $display("[TB] random divisions");
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 4'($urandom_range(1, 15));
            applyStimulus(ra, rb);
            checkOutput();
        end

        $display("[TB] reset in the middle of a division");
        applyStimulus(8'd200, 4'd7);
        repeat (3) @(posedge clk_div);
        #3 reset_div = 1'b1;
        #1;
        chk("midrst_busy", busy_div, 0);
        chk("midrst_done", done_div, 0);
        chk("midrst_quotient", quotient_div, 0);
        chk("midrst_remainder", remainder_div, 0);
        chk("midrst_dbz", div_by_zero_div, 0);
        sb.delete();
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;
        @(posedge clk_div);
        #2 reset_div = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk_div);
            #1;
            if (done_div !== 1'b0) done_cnt++;
        end
        chk("no_done_after_reset", done_cnt, 0);
        applyStimulus(8'd200, 4'd7);
        checkOutput();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
